// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for fifo_write_arbiter.
// Optional build macro: FIFO_ARB_STRICT_PRIO_EN (requester 0 gets strict priority).
package fifo_arb_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int MAX_REQ        = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First valid index at or above ptr, wrapping modulo n (n in 2..MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t   res;
    logic [3:0] cand;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int off = 0; off < MAX_REQ; off++) begin
      cand = {1'b0, ptr} + 4'(off);
      if (cand >= 4'(n)) begin
        cand = cand - 4'(n);
      end else begin
        cand = cand;
      end
      if ((off < n) && !res.found && valid[cand[2:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[2:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester handshake plus Avalon-MM write-port bundle for fifo_write_arbiter.
// master = the arbiter, slave = producers/FIFO side.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         fifo_writedata;
  logic                      fifo_write;
  logic                      fifo_address;
  logic                      fifo_waitrequest;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_data, fifo_waitrequest,
    output req_ready, fifo_writedata, fifo_write, fifo_address, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_waitrequest,
    input  req_ready, fifo_writedata, fifo_write, fifo_address, grant_id, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Round-robin winner select with registered rotation pointer.
// With FIFO_ARB_STRICT_PRIO_EN, index 0 wins whenever valid and the pointer
// rotates only over indices 1..NUM_REQ-1.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic                       advance_i,
  output logic                       found_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext_s;
  rr_pick_t           pick_s;
  logic               found_s;
  logic [ID_W-1:0]    grant_s;

`ifdef FIFO_ARB_STRICT_PRIO_EN
  // Requester 0 first; others rotate, and the pointer skips index 0 on wrap.
  always_comb begin
    valid_ext_s    = MAX_REQ'(valid_i);
    valid_ext_s[0] = 1'b0;
    pick_s         = rr_pick(valid_ext_s, 3'(ptr_q), NUM_REQ);
    ptr_d          = ptr_q;
    if (valid_i[0]) begin
      found_s = 1'b1;
      grant_s = '0;
    end else begin
      found_s = pick_s.found;
      grant_s = ID_W'(pick_s.idx);
      if (advance_i && pick_s.found) begin
        ptr_d = (grant_s == LAST_IDX) ? ID_W'(1) : grant_s + ID_W'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end
  end
`else
  // Pure rotation: scan upward from the pointer, pointer moves past the winner.
  always_comb begin
    valid_ext_s = MAX_REQ'(valid_i);
    pick_s      = rr_pick(valid_ext_s, 3'(ptr_q), NUM_REQ);
    found_s     = pick_s.found;
    grant_s     = ID_W'(pick_s.idx);
    if (advance_i && pick_s.found) begin
      ptr_d = (grant_s == LAST_IDX) ? '0 : grant_s + ID_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end
`endif

  // Rotation pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign found_o = found_s;
  assign grant_o = grant_s;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the fifo_1_in Avalon-MM write port among NUM_REQ producers.
// Holds each word until waitrequest drops, back-to-back at 1 word/cycle,
// and raises a sticky timeout_err if the slave stalls for WAIT_TIMEOUT cycles.
// Optional build macro: FIFO_ARB_STRICT_PRIO_EN (see rr_arbiter).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  fifo_write_arbiter_if.master bus,
  output logic                 timeout_err,
  input  logic                 err_clr
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               err_q, err_d;

  logic               found_s;
  logic [ID_W-1:0]    win_s;
  logic               accept_s;
  logic               stalled_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [NUM_REQ-1:0] ready_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .valid_i  (bus.req_valid),
    .advance_i(accept_s),
    .found_o  (found_s),
    .grant_o  (win_s)
  );

  // State transitions; an accept can happen in IDLE or as the current word completes.
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    stalled_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          accept_s = 1'b1;
          state_d  = WRITE;
        end else begin
          state_d  = IDLE;
        end
      end
      WRITE: begin
        if (bus.fifo_waitrequest) begin
          stalled_s = 1'b1;
          state_d   = WRITE;
        end else if (found_s) begin
          accept_s  = 1'b1;
          state_d   = WRITE;
        end else begin
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Winner data mux, hold/grant capture, one-hot ready.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_s == ID_W'(i)) begin
        sel_data_s = bus.req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    if (accept_s) begin
      hold_d  = sel_data_s;
      gid_d   = win_s;
      ready_s = NUM_REQ'(1) << win_s;
    end else begin
      hold_d  = hold_q;
      gid_d   = gid_q;
      ready_s = '0;
    end
  end

  // Saturating stall counter and sticky watchdog flag (set beats clear).
  always_comb begin
    if (stalled_s) begin
      stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
    end else begin
      stall_d = '0;
    end
    if (stalled_s && (stall_q == CNT_MAX)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State, hold register, grant, stall counter and error flag.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gid_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gid_q   <= gid_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready      = ready_s;
  assign bus.fifo_write     = (state_q == WRITE);
  assign bus.busy           = (state_q == WRITE);
  assign bus.fifo_writedata = hold_q;
  assign bus.fifo_address   = 1'b0;
  assign bus.grant_id       = gid_q;
  assign timeout_err        = err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus hand-written
// sequences for fairness, stall, watchdog, async reset and strict priority.
module tb_fifo_write_arbiter;
`ifdef FIFO_ARB_STRICT_PRIO_EN
  localparam int NUM_REQ = 3;
`else
  localparam int NUM_REQ = 2;
`endif
  localparam int DATA_W       = 32;
  localparam int WAIT_TIMEOUT = 16;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic err_clr;
  logic timeout_err;
  int   tests = 0;
  int   fails = 0;

  fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [2:0]  valid;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        wr_wait;
    logic [2:0]  exp_ready;
    logic        exp_write;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [2:0]  exp_gid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic w);
    bus.req_valid        = NUM_REQ'(v);
    bus.req_data         = '0;
    bus.req_data[31:0]   = d0;
    bus.req_data[63:32]  = d1;
    bus.fifo_waitrequest = w;
  endtask

  task automatic next_cycle();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, n1, acc, seen, first_c, last_c;
    logic [31:0] exp_w;
    logic [2:0]  v;
    logic        w;

    //        valid   d0            d1            wait  ready  wr   chkd  data          gid
    vecs[0] = {3'b000, 32'h0,        32'h0,        1'b0, 3'b000, 1'b0, 1'b1, 32'h0,        3'd0};
    vecs[1] = {3'b001, 32'hDEADBEEF, 32'h0,        1'b0, 3'b001, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[2] = {3'b000, 32'h0,        32'h0,        1'b0, 3'b000, 1'b1, 1'b1, 32'hDEADBEEF, 3'd0};
    vecs[3] = {3'b000, 32'h0,        32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[4] = {3'b010, 32'h0,        32'h000000B1, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0,        3'd0};
    vecs[5] = {3'b001, 32'h000000A2, 32'h0,        1'b0, 3'b001, 1'b1, 1'b1, 32'h000000B1, 3'd1};
    vecs[6] = {3'b011, 32'h0000FFFF, 32'h0000EEEE, 1'b1, 3'b000, 1'b1, 1'b1, 32'h000000A2, 3'd0};
    vecs[7] = {3'b010, 32'h0,        32'h000000B4, 1'b0, 3'b010, 1'b1, 1'b1, 32'h000000A2, 3'd0};
    vecs[8] = {3'b000, 32'h0,        32'h0,        1'b0, 3'b000, 1'b1, 1'b1, 32'h000000B4, 3'd1};
    vecs[9] = {3'b000, 32'h0,        32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 32'h0,        3'd1};

    reset_reset_n = 1'b0;
    err_clr       = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;

    // Table: one row per cycle, outputs checked mid-cycle.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].wr_wait);
      @(negedge clk_clk);
      chk($sformatf("vec%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d write", i), 32'(bus.fifo_write), 32'(vecs[i].exp_write));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].exp_write));
      chk($sformatf("vec%0d gid", i), 32'(bus.grant_id), 32'(vecs[i].exp_gid));
      if (vecs[i].chk_data) begin
        chk($sformatf("vec%0d data", i), bus.fifo_writedata, vecs[i].exp_data);
      end else begin
        chk($sformatf("vec%0d addr", i), 32'(bus.fifo_address), 32'h0);
      end
      if (i == 0) begin
        chk("reset timeout_err", 32'(timeout_err), 32'h0);
      end
      next_cycle();
    end

`ifndef FIFO_ARB_STRICT_PRIO_EN
    // Fairness: both requesters always valid, 8 words alternate without bubbles.
    n0 = 0; n1 = 0; acc = 0; seen = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      drive((acc < 8) ? 3'b011 : 3'b000, 32'h100 + 32'(n0), 32'h200 + 32'(n1), 1'b0);
      @(negedge clk_clk);
      if (bus.fifo_write) begin
        exp_w = ((seen % 2) == 0) ? 32'h100 + 32'(seen / 2) : 32'h200 + 32'(seen / 2);
        chk($sformatf("fair word%0d", seen), bus.fifo_writedata, exp_w);
        seen++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus.req_valid[0] && bus.req_ready[0]) begin n0++; acc++; end
      if (bus.req_valid[1] && bus.req_ready[1]) begin n1++; acc++; end
      next_cycle();
    end
    chk("fair count", seen, 8);
    chk("fair no bubbles", last_c - first_c + 1, 8);
`endif

    // Stall: waitrequest high for 5 cycles while the second word is on the bus.
    n0 = 0; seen = 0;
    for (int c = 0; c < 14; c++) begin
      w = (c >= 2) && (c <= 6);
      drive((n0 < 4) ? 3'b001 : 3'b000, 32'h300 + 32'(n0), 32'h0, w);
      @(negedge clk_clk);
      if (w) begin
        chk($sformatf("stall c%0d write", c), 32'(bus.fifo_write), 32'h1);
        chk($sformatf("stall c%0d data", c), bus.fifo_writedata, 32'h301);
        chk($sformatf("stall c%0d gid", c), 32'(bus.grant_id), 32'h0);
        chk($sformatf("stall c%0d ready", c), 32'(bus.req_ready), 32'h0);
      end
      if (bus.fifo_write && !bus.fifo_waitrequest) begin
        chk($sformatf("stall word%0d", seen), bus.fifo_writedata, 32'h300 + 32'(seen));
        seen++;
      end
      if (bus.req_valid[0] && bus.req_ready[0]) n0++;
      next_cycle();
    end
    chk("stall count", seen, 4);

    // Watchdog: stuck waitrequest, clear ignored while stalled, honoured after.
    for (int c = 0; c < 23; c++) begin
      drive((c == 0) ? 3'b001 : 3'b000, 32'hCAFE0001, 32'h0, (c >= 1) && (c <= 19));
      err_clr = (c == 18) || (c == 21);
      @(negedge clk_clk);
      if (c == 5)  chk("wd held data", bus.fifo_writedata, 32'hCAFE0001);
      if (c == 16) chk("wd before bound", 32'(timeout_err), 32'h0);
      if (c == 17) chk("wd set", 32'(timeout_err), 32'h1);
      if (c == 19) chk("wd clr while stalled", 32'(timeout_err), 32'h1);
      if (c == 20) chk("wd still writing", 32'(bus.fifo_write), 32'h1);
      if (c == 21) chk("wd sticky after release", 32'(timeout_err), 32'h1);
      if (c == 22) chk("wd cleared", 32'(timeout_err), 32'h0);
      next_cycle();
    end
    err_clr = 1'b0;

    // Async reset mid-WRITE; pointer left at 1 beforehand so the tie proves it reset.
    drive(3'b001, 32'h5A5A0000, 32'h0, 1'b1);
    @(negedge clk_clk);
    chk("rst pre accept", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 1'b1);
    #2;
    chk("rst pre write", 32'(bus.fifo_write), 32'h1);
    reset_reset_n = 1'b0;
    #1;
    chk("rst async write drop", 32'(bus.fifo_write), 32'h0);
    chk("rst async busy", 32'(bus.busy), 32'h0);
    chk("rst writedata", bus.fifo_writedata, 32'h0);
    @(posedge clk_clk);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    drive(3'b011, 32'h11111111, 32'h22222222, 1'b0);
    @(negedge clk_clk);
    chk("rst tie ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 1'b0);
    @(negedge clk_clk);
    chk("rst tie data", bus.fifo_writedata, 32'h11111111);
    chk("rst tie gid", 32'(bus.grant_id), 32'h0);
    next_cycle();

`ifdef FIFO_ARB_STRICT_PRIO_EN
    // Strict priority: req0 wins 4 times, then 1 and 2 alternate.
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      v = (acc < 4) ? 3'b111 : ((acc < 8) ? 3'b110 : 3'b000);
      drive(v, 32'h0, 32'h0, 1'b0);
      @(negedge clk_clk);
      if (acc < 8) begin
        if (acc < 4)                  exp_w = 32'h1;
        else if (((acc - 4) % 2) == 0) exp_w = 32'h2;
        else                          exp_w = 32'h4;
        chk($sformatf("prio grant%0d", acc), 32'(bus.req_ready), exp_w);
      end
      if ((bus.req_valid & bus.req_ready) != '0) acc++;
      next_cycle();
    end
    chk("prio count", acc, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single Avalon-MM write port of the fifo_1_in FIFO slave between NUM_REQ on-chip producers, e.g. the controller-input sampler and the game-event generator.
- Each producer offers 32-bit words over a valid/ready handshake. The block grants round-robin, holds each word on the Avalon port until waitrequest drops, and sustains 1 word/cycle.
- A watchdog flags a FIFO slave that stalls waitrequest beyond a bound.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- DATA_W, 32: word width; matches fifo_1_in_writedata.
- WAIT_TIMEOUT, 1024: consecutive stalled cycles before timeout_err sets; must be ≥ 2.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; a word is transferred when valid&ready are both high at a clock edge.
- fifo_writedata  out  DATA_W  to fifo_1_in_writedata.
- fifo_write  out  1  to fifo_1_in_write.
- fifo_address  out  1  to fifo_1_in_address; constant 0.
- fifo_waitrequest  in  1  from fifo_1_in_waitrequest.
- grant_id  out  $clog2(NUM_REQ)  source of the word currently on the bus.
- busy  out  1  high while fifo_write is asserted.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset values: fifo_write=0, fifo_writedata=0, fifo_address=0, req_ready=0, grant_id=0, busy=0, timeout_err=0, rr pointer=0, stall counter=0, state=IDLE.
- Reset mid-transfer: the held word is discarded and the FIFO sees fifo_write drop asynchronously. Producers must re-offer the word.
- State IDLE:
  - fifo_write=0.
  - If any req_valid is high, req_ready is driven combinationally for the winner.
  - Winner = first valid index found scanning from the rr pointer upward, wrapping modulo NUM_REQ.
  - On the next edge: latch the winner's data into the hold register, set grant_id, set rr pointer = winner+1 (mod NUM_REQ), go to WRITE.
- State WRITE:
  - fifo_write=1; fifo_writedata and grant_id are stable from the hold register.
  - waitrequest=1: hold everything; req_ready=0; stall counter increments.
  - waitrequest=0: the word completes at this edge and the stall counter resets. If any req_valid is high, the next winner is accepted in the same cycle (req_ready high) and the state stays WRITE, giving zero-bubble back-to-back transfers. Otherwise go to IDLE.
- Latency: valid-to-fifo_write is 1 cycle. Steady state is 1 word/cycle when waitrequest=0.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Watchdog: when the stall counter reaches WAIT_TIMEOUT-1 with waitrequest still high, timeout_err sets. The counter saturates, and the write is never abandoned, per Avalon rules.
- Error clear: err_clr clears timeout_err. If err_clr and the set condition occur in the same cycle, set wins.
- req_data is sampled only on an accept edge; producer data changes at other times are ignored.

Optional Feature:
- Macro FIFO_ARB_STRICT_PRIO_EN.
- Defined: requester 0 always wins when valid; the remaining requesters are round-robin among themselves; the rr pointer never selects index 0.
- Undefined: pure round-robin across all requesters as above.

Decomposition:
- Package fifo_arb_pkg holds:
  - arb_state_t enum {IDLE, WRITE};
  - DATA_W_DEFAULT constant;
  - a function rr_pick(valid, ptr) returning the winner index plus a found bit.
- Sub-module rr_arbiter: combinational winner select plus the registered pointer, parameterised by NUM_REQ and reused by the strict-priority variant.

Test Plan:
- Single word: req_valid=01, data0=0xDEADBEEF, waitrequest=0 → req_ready=01 in cycle 0; fifo_write=1 with writedata=0xDEADBEEF and grant_id=0 in cycle 1; IDLE in cycle 2.
- Fairness: both valid continuously for 8 words (data0=0x100+n, data1=0x200+n) → FIFO sees alternating 0x100,0x200,0x101,…, with no idle cycles between words.
- Stall: waitrequest held high 5 cycles mid-stream → writedata and grant_id stable across those 5 cycles, req_ready=0, no word lost or duplicated.
- Timeout: WAIT_TIMEOUT=16, waitrequest stuck high → timeout_err rises after 16 stalled cycles; pulse err_clr while still stalled → flag stays set. Release waitrequest, then pulse err_clr → flag clears.
- Reset mid-WRITE: assert reset_reset_n=0 while fifo_write=1 → fifo_write drops immediately (async). After release, the rr pointer is 0 and requester 0 wins the first tie.
- With FIFO_ARB_STRICT_PRIO_EN, NUM_REQ=3, all valid → grants 0,0,0,… until req0 deasserts, then 1,2,1,2.
